// File: rtl/insn_decode_stage.sv
// RV32I decode stage: combinational opcode classification, registered result
// behind a two-entry skid buffer, plus a saturating illegal-instruction counter.
module insn_decode_stage #(
  parameter int TAG_W = 32,
  parameter bit EN_M  = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_class,
  output logic             out_illegal,
  output logic [31:0]      out_insn,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  input  logic             err_clr,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             err_sticky
);

  typedef enum logic [1:0] {EMPTY, HOLD, FULL} state_t;

  state_t           state, state_nxt;
  logic [3:0]       dec_class;
  logic [31:0]      skid_insn;
  logic [TAG_W-1:0] skid_tag;
  logic [3:0]       skid_class;
  logic             accept, drain, ill_drain;
  logic [2:0]       f3;
  logic [6:0]       f7;

  assign f3 = in_insn[14:12];
  assign f7 = in_insn[31:25];

  always_comb begin
    dec_class = 4'd15;
    unique case (in_insn[6:0])
      7'b0110111: dec_class = 4'd0;
      7'b0010111: dec_class = 4'd1;
      7'b1101111: dec_class = 4'd2;
      7'b1100111: if (f3 == 3'b000) dec_class = 4'd3;
      7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) dec_class = 4'd4;
      7'b0000011: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) dec_class = 4'd5;
      7'b0100011: if (f3 < 3'b011) dec_class = 4'd6;
      7'b0010011: begin
        if (f3 == 3'b001)
          dec_class = (f7 == 7'b0000000) ? 4'd7 : 4'd15;
        else if (f3 == 3'b101)
          dec_class = (f7 == 7'b0000000 || f7 == 7'b0100000) ? 4'd7 : 4'd15;
        else
          dec_class = 4'd7;
      end
      7'b0110011: begin
        if (f7 == 7'b0000000)
          dec_class = 4'd8;
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
          dec_class = 4'd8;
        else if (f7 == 7'b0000001 && EN_M)
          dec_class = 4'd8;
      end
      7'b0001111: if (f3 == 3'b000 || f3 == 3'b001) dec_class = 4'd9;
      7'b1110011: dec_class = 4'd10;
      default:    dec_class = 4'd15;
    endcase
  end

  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid & out_ready;
  assign ill_drain = drain & out_illegal;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) state_nxt = HOLD;
        HOLD: begin
          if (accept && !drain)      state_nxt = FULL;
          else if (drain && !accept) state_nxt = EMPTY;
        end
        FULL:  if (drain) state_nxt = HOLD;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid   = (state != EMPTY);
    in_ready    = (state != FULL);
    out_illegal = out_valid && (out_class == 4'd15);
  end

  // Output register takes fresh input when empty or when draining in HOLD;
  // FULL refills it from the skid entry so ordering is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_class <= 4'd15;
    end else if (!flush) begin
      if ((state == EMPTY && accept) || (state == HOLD && accept && drain)) begin
        out_insn  <= in_insn;
        out_tag   <= in_tag;
        out_class <= dec_class;
      end else if (state == FULL && drain) begin
        out_insn  <= skid_insn;
        out_tag   <= skid_tag;
        out_class <= skid_class;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == HOLD && accept && !drain) begin
      skid_insn  <= in_insn;
      skid_tag   <= in_tag;
      skid_class <= dec_class;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt <= '0;
      err_sticky  <= 1'b0;
    end else if (err_clr) begin
      illegal_cnt <= ill_drain ? CNT_W'(1) : '0;
      err_sticky  <= ill_drain;
    end else if (ill_drain) begin
      if (illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_insn_decode_stage.sv
// Scoreboard bench: default instance plus an EN_M=1/CNT_W=2 instance on shared stimulus.
module tb_insn_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [31:0] in_insn = '0, in_tag = '0;

  logic        in_ready0, out_valid0, out_illegal0, err_sticky0;
  logic [3:0]  out_class0;
  logic [31:0] out_insn0, out_tag0;
  logic [15:0] illegal_cnt0;
  logic        in_ready1, out_valid1, out_illegal1, err_sticky1;
  logic [3:0]  out_class1;
  logic [31:0] out_insn1, out_tag1;
  logic [1:0]  illegal_cnt1;

  insn_decode_stage dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_insn(in_insn),
    .in_tag(in_tag), .out_valid(out_valid0), .out_ready(out_ready), .out_class(out_class0),
    .out_illegal(out_illegal0), .out_insn(out_insn0), .out_tag(out_tag0), .flush(flush),
    .err_clr(err_clr), .illegal_cnt(illegal_cnt0), .err_sticky(err_sticky0));

  insn_decode_stage #(.TAG_W(32), .EN_M(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_insn(in_insn),
    .in_tag(in_tag), .out_valid(out_valid1), .out_ready(out_ready), .out_class(out_class1),
    .out_illegal(out_illegal1), .out_insn(out_insn1), .out_tag(out_tag1), .flush(flush),
    .err_clr(err_clr), .illegal_cnt(illegal_cnt1), .err_sticky(err_sticky1));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] tag;
    logic [3:0]  cls0;
    logic [3:0]  cls1;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, passed = 0;
  logic [15:0] m_cnt0 = '0;
  logic [1:0]  m_cnt1 = '0;
  logic        m_st0 = 1'b0, m_st1 = 1'b0;
  logic [31:0] tag_ctr = 32'h100;

  function automatic logic [3:0] model_class(input logic [31:0] w, input bit en_m);
    logic [2:0] fn3;
    logic [6:0] fn7;
    fn3 = w[14:12];
    fn7 = w[31:25];
    case (w[6:0])
      7'h37: return 4'd0;
      7'h17: return 4'd1;
      7'h6f: return 4'd2;
      7'h67: return (fn3 == 0) ? 4'd3 : 4'd15;
      7'h63: return (fn3 == 2 || fn3 == 3) ? 4'd15 : 4'd4;
      7'h03: return (fn3 == 3 || fn3 == 6 || fn3 == 7) ? 4'd15 : 4'd5;
      7'h23: return (fn3 >= 3) ? 4'd15 : 4'd6;
      7'h13: begin
        if (fn3 == 1 && fn7 != 0) return 4'd15;
        if (fn3 == 5 && fn7 != 0 && fn7 != 7'h20) return 4'd15;
        return 4'd7;
      end
      7'h33: begin
        if (fn7 == 0) return 4'd8;
        if (fn7 == 7'h20) return (fn3 == 0 || fn3 == 5) ? 4'd8 : 4'd15;
        if (fn7 == 7'h01 && en_m) return 4'd8;
        return 4'd15;
      end
      7'h0f: return (fn3 <= 1) ? 4'd9 : 4'd15;
      7'h73: return 4'd10;
      default: return 4'd15;
    endcase
  endfunction

  // One clock: pre-edge scoreboard compare and model update, then post-edge counter compare.
  task automatic step();
    exp_t e;
    bit   acc, drn;
    @(negedge clk);
    if (!rst && out_valid0 === 1'b1) begin
      checks++;
      if (q.size() == 0) $display("FAIL unexpected_out: insn=%h tag=%h with empty scoreboard", out_insn0, out_tag0);
      else begin
        e = q[0];
        if (out_insn0 !== e.insn || out_tag0 !== e.tag || out_class0 !== e.cls0 || out_illegal0 !== (e.cls0 == 15))
          $display("FAIL out0: got insn=%h tag=%h class=%0d ill=%b, want insn=%h tag=%h class=%0d", out_insn0, out_tag0, out_class0, out_illegal0, e.insn, e.tag, e.cls0);
        else passed++;
        checks++;
        if (out_valid1 !== 1'b1 || out_insn1 !== e.insn || out_class1 !== e.cls1)
          $display("FAIL out1: got v=%b insn=%h class=%0d, want v=1 insn=%h class=%0d", out_valid1, out_insn1, out_class1, e.insn, e.cls1);
        else passed++;
      end
    end
    acc = !rst && !flush && in_valid && (in_ready0 === 1'b1);
    drn = !rst && out_ready && (out_valid0 === 1'b1) && q.size() > 0;
    if (rst) begin
      q.delete(); m_cnt0 = '0; m_cnt1 = '0; m_st0 = 0; m_st1 = 0;
    end else begin
      bit i0 = 0, i1 = 0;
      if (drn) begin
        e = q.pop_front();
        i0 = (e.cls0 == 15); i1 = (e.cls1 == 15);
      end
      if (err_clr) begin
        m_cnt0 = i0 ? 16'd1 : '0; m_st0 = i0;
        m_cnt1 = i1 ? 2'd1 : '0;  m_st1 = i1;
      end else begin
        if (i0) begin if (m_cnt0 != '1) m_cnt0++; m_st0 = 1; end
        if (i1) begin if (m_cnt1 != '1) m_cnt1++; m_st1 = 1; end
      end
      if (flush) q.delete();
      else if (acc) q.push_back('{in_insn, in_tag, model_class(in_insn, 0), model_class(in_insn, 1)});
    end
    @(posedge clk); #1;
    checks++;
    if (illegal_cnt0 !== m_cnt0 || err_sticky0 !== m_st0 || illegal_cnt1 !== m_cnt1 || err_sticky1 !== m_st1)
      $display("FAIL counters: got cnt0=%0d st0=%b cnt1=%0d st1=%b, want cnt0=%0d st0=%b cnt1=%0d st1=%b",
               illegal_cnt0, err_sticky0, illegal_cnt1, err_sticky1, m_cnt0, m_st0, m_cnt1, m_st1);
    else passed++;
  endtask

  task automatic drive(input logic [31:0] w);
    in_valid = 1; in_insn = w; in_tag = tag_ctr; tag_ctr++;
  endtask

  task automatic drain_all();
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    step();
    checks++;
    if (q.size() != 0 || out_valid0 !== 1'b0) $display("FAIL drain_timeout: left=%0d out_valid=%b, want 0/0", q.size(), out_valid0);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; in_insn = 32'h13; flush = 1; err_clr = 1;
    step();
    rst = 0; in_valid = 0; flush = 0; err_clr = 0;
    checks++;
    if (in_ready0 !== 1 || out_valid0 !== 0 || out_class0 !== 4'd15 || out_illegal0 !== 0)
      $display("FAIL reset: got rdy=%b v=%b class=%0d ill=%b, want 1 0 15 0", in_ready0, out_valid0, out_class0, out_illegal0);
    else passed++;
  endtask

  task automatic test_addi();
    out_ready = 1; drive(32'h00000013);
    step();
    in_valid = 0;
    checks++;
    if (out_valid0 !== 1 || out_class0 !== 4'd7 || out_tag0 !== tag_ctr - 1)
      $display("FAIL addi_latency: got v=%b class=%0d tag=%h, want 1 7 %h", out_valid0, out_class0, out_tag0, tag_ctr - 1);
    else passed++;
    drain_all();
  endtask

  task automatic test_m_ext();
    drive(32'h02000033); step();
    drain_all();
    checks++;
    if (illegal_cnt0 !== 16'd1 || err_sticky0 !== 1 || illegal_cnt1 !== 2'd0)
      $display("FAIL m_ext: got cnt0=%0d st0=%b cnt1=%0d, want 1 1 0", illegal_cnt0, err_sticky0, illegal_cnt1);
    else passed++;
  endtask

  task automatic test_branch();
    drive(32'h00001063); step();
    drive(32'h00002063); step();
    drain_all();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    drive(32'h00100093); step();
    drive(32'h00200113); step();
    drive(32'h00300193);
    checks++;
    if (in_ready0 !== 0) $display("FAIL bp_ready: got in_ready=%b, want 0", in_ready0);
    else passed++;
    step(); step();
    checks++;
    if (q.size() != 2) $display("FAIL bp_accepted: got %0d held, want 2", q.size());
    else passed++;
    drain_all();
  endtask

  task automatic test_saturate();
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin drive(32'h00000000); step(); end
    in_valid = 0; step(); step();
    checks++;
    if (illegal_cnt1 !== 2'd3) $display("FAIL saturate: got cnt1=%0d, want 3", illegal_cnt1);
    else passed++;
    drive(32'h0000200f); step();
    in_valid = 0; err_clr = 1; step();
    err_clr = 0;
    checks++;
    if (illegal_cnt1 !== 2'd1 || err_sticky1 !== 1 || illegal_cnt0 !== 16'd1)
      $display("FAIL clr_with_drain: got cnt1=%0d st1=%b cnt0=%0d, want 1 1 1", illegal_cnt1, err_sticky1, illegal_cnt0);
    else passed++;
    err_clr = 1; step(); err_clr = 0;
    checks++;
    if (illegal_cnt0 !== 0 || err_sticky0 !== 0 || illegal_cnt1 !== 0 || err_sticky1 !== 0)
      $display("FAIL clr_alone: got cnt0=%0d st0=%b cnt1=%0d st1=%b, want all 0", illegal_cnt0, err_sticky0, illegal_cnt1, err_sticky1);
    else passed++;
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive(32'h00000037); step();
    drive(32'h00000017); step();
    drive(32'h0000006f); flush = 1; step();
    flush = 0; in_valid = 0;
    checks++;
    if (out_valid0 !== 0 || in_ready0 !== 1) $display("FAIL flush: got v=%b rdy=%b, want 0 1", out_valid0, in_ready0);
    else passed++;
    out_ready = 1;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl[16] = '{32'h00001013, 32'h02001013, 32'h40005013, 32'h20005013,
                             32'h40000033, 32'h40001033, 32'h0000100f, 32'h00003003,
                             32'h00003023, 32'h00002023, 32'h00001067, 32'h00000073,
                             32'h02004033, 32'h00000067, 32'h00006003, 32'h00000031};
    int n;
    out_ready = 1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      if (in_ready0 === 1'b1) n++;
      step();
    end
    checks++;
    if (n != 16) $display("FAIL throughput: got %0d accepts in 16 cycles, want 16", n);
    else passed++;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) drive(($urandom_range(0, 1) != 0) ? tbl[$urandom_range(0, 15)] : $urandom);
      else in_valid = 0;
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    drain_all();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_m_ext();
    test_branch();
    test_backpressure();
    test_saturate();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
